// File: rtl/sram_arbiter_pkg.sv
// Shared constants for the two-port SRAM arbiter: FSM encoding, port indices
// and the address bits that pick the chip and the byte lane.
package sram_arbiter_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 8;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_READ     = 3'd1;
  localparam logic [2:0] ST_WR_SETUP = 3'd2;
  localparam logic [2:0] ST_WR_PULSE = 3'd3;
  localparam logic [2:0] ST_WR_HOLD  = 3'd4;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int unsigned CHIP_BIT = 19;
  localparam int unsigned LANE_BIT = 0;

  function automatic logic [DATA_W-1:0] lane_byte(input logic [15:0] word, input logic lane);
    return lane ? word[15:8] : word[7:0];
  endfunction

endpackage

// File: rtl/sram_req_slot.sv
// One-deep request latch per port: captures a strobe (write wins over read),
// holds it until granted; a new strobe always replaces the held request.
module sram_req_slot
  import sram_arbiter_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_begin_wr,
  input  logic              i_begin_rd,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_grant,
  output logic              o_pending,
  output logic              o_wr,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_data
);

  logic              r_pending;
  logic              r_wr;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;

  // A strobe in the grant cycle refills the slot, so it takes priority over the clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= 1'b0;
      r_wr      <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else if (i_begin_wr || i_begin_rd) begin
      r_pending <= 1'b1;
      r_wr      <= i_begin_wr;
      r_addr    <= i_addr;
      r_data    <= i_data;
    end else if (i_grant) begin
      r_pending <= 1'b0;
    end
  end

  assign o_pending = r_pending;
  assign o_wr      = r_wr;
  assign o_addr    = r_addr;
  assign o_data    = r_data;

endmodule

// File: rtl/sram_arbiter.sv
// Two-port byte-wide arbiter over two 256K x 16 async SRAMs (flat 1 MB space).
// Port A has priority except directly after an A grant, so B never starves.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 2
) (
  input  logic              mclk,
  input  logic              reset,
  output logic [17:0]       sram_a,
  output logic              sram_oe,
  output logic              sram_we,
  inout  wire  [15:0]       sram1_io,
  output logic              sram1_ce,
  output logic              sram1_ub,
  output logic              sram1_lb,
  inout  wire  [15:0]       sram2_io,
  output logic              sram2_ce,
  output logic              sram2_ub,
  output logic              sram2_lb,
  input  logic              a_begin_wr,
  input  logic              a_begin_rd,
  output logic              a_finish,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data_wr,
  output logic [DATA_W-1:0] a_data_rd,
  input  logic              b_begin_wr,
  input  logic              b_begin_rd,
  output logic              b_finish,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data_wr,
  output logic [DATA_W-1:0] b_data_rd
);

  logic              w_a_pend, w_a_wr, w_b_pend, w_b_wr;
  logic [ADDR_W-1:0] w_a_addr, w_b_addr, w_g_addr;
  logic [DATA_W-1:0] w_a_data, w_b_data, w_g_data;
  logic              w_idle, w_sel_b, w_grant_a, w_grant_b, w_g_wr;
  logic              w_busy, w_drive;
  logic [15:0]       w_rd_word;

  logic [2:0]        r_state;
  logic [7:0]        r_cnt;
  logic              r_port, r_chip, r_lane, r_last_a;
  logic [17:0]       r_sram_a;
  logic [DATA_W-1:0] r_wdata;
  logic              r_a_finish, r_b_finish;
  logic [DATA_W-1:0] r_a_data_rd, r_b_data_rd;

  sram_req_slot u_slot_a (
    .i_clk      (mclk),
    .i_rst_n    (reset),
    .i_begin_wr (a_begin_wr),
    .i_begin_rd (a_begin_rd),
    .i_addr     (a_addr),
    .i_data     (a_data_wr),
    .i_grant    (w_grant_a),
    .o_pending  (w_a_pend),
    .o_wr       (w_a_wr),
    .o_addr     (w_a_addr),
    .o_data     (w_a_data)
  );

  sram_req_slot u_slot_b (
    .i_clk      (mclk),
    .i_rst_n    (reset),
    .i_begin_wr (b_begin_wr),
    .i_begin_rd (b_begin_rd),
    .i_addr     (b_addr),
    .i_data     (b_data_wr),
    .i_grant    (w_grant_b),
    .o_pending  (w_b_pend),
    .o_wr       (w_b_wr),
    .o_addr     (w_b_addr),
    .o_data     (w_b_data)
  );

  assign w_idle    = (r_state == ST_IDLE);
  assign w_sel_b   = w_b_pend && (!w_a_pend || r_last_a);
  assign w_grant_b = w_idle && w_sel_b;
  assign w_grant_a = w_idle && w_a_pend && !w_sel_b;
  assign w_g_wr    = w_sel_b ? w_b_wr   : w_a_wr;
  assign w_g_addr  = w_sel_b ? w_b_addr : w_a_addr;
  assign w_g_data  = w_sel_b ? w_b_data : w_a_data;

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_port      <= PORT_A;
      r_chip      <= 1'b0;
      r_lane      <= 1'b0;
      r_last_a    <= 1'b0;
      r_sram_a    <= '0;
      r_wdata     <= '0;
      r_a_finish  <= 1'b0;
      r_b_finish  <= 1'b0;
      r_a_data_rd <= '0;
      r_b_data_rd <= '0;
    end else begin
      r_a_finish <= 1'b0;
      r_b_finish <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_a || w_grant_b) begin
            r_port   <= w_grant_b ? PORT_B : PORT_A;
            r_last_a <= w_grant_a;
            r_sram_a <= w_g_addr[18:1];
            r_chip   <= w_g_addr[CHIP_BIT];
            r_lane   <= w_g_addr[LANE_BIT];
            r_wdata  <= w_g_data;
            r_cnt    <= '0;
            r_state  <= w_g_wr ? ST_WR_SETUP : ST_READ;
          end
        end
        ST_READ: begin
          if (r_cnt == 8'(RD_CYCLES - 1)) begin
            if (r_port == PORT_B) r_b_data_rd <= lane_byte(w_rd_word, r_lane);
            else                  r_a_data_rd <= lane_byte(w_rd_word, r_lane);
            r_a_finish <= (r_port == PORT_A);
            r_b_finish <= (r_port == PORT_B);
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_WR_SETUP: begin
          r_cnt   <= '0;
          r_state <= ST_WR_PULSE;
        end
        ST_WR_PULSE: begin
          if (r_cnt == 8'(WR_CYCLES - 1)) r_state <= ST_WR_HOLD;
          else                            r_cnt   <= r_cnt + 8'd1;
        end
        ST_WR_HOLD: begin
          r_a_finish <= (r_port == PORT_A);
          r_b_finish <= (r_port == PORT_B);
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Strobes decode from the registered state so an async reset releases the bus at once.
  assign w_busy  = !w_idle;
  assign w_drive = (r_state == ST_WR_SETUP) || (r_state == ST_WR_PULSE) || (r_state == ST_WR_HOLD);

  assign sram_a   = r_sram_a;
  assign sram_oe  = !(r_state == ST_READ);
  assign sram_we  = !(r_state == ST_WR_PULSE);
  assign sram1_ce = !(w_busy && !r_chip);
  assign sram2_ce = !(w_busy &&  r_chip);
  assign sram1_ub = !(w_busy && !r_chip &&  r_lane);
  assign sram1_lb = !(w_busy && !r_chip && !r_lane);
  assign sram2_ub = !(w_busy &&  r_chip &&  r_lane);
  assign sram2_lb = !(w_busy &&  r_chip && !r_lane);

  assign sram1_io = (w_drive && !r_chip) ? {r_wdata, r_wdata} : 'z;
  assign sram2_io = (w_drive &&  r_chip) ? {r_wdata, r_wdata} : 'z;
  assign w_rd_word = r_chip ? sram2_io : sram1_io;

  assign a_finish  = r_a_finish;
  assign b_finish  = r_b_finish;
  assign a_data_rd = r_a_data_rd;
  assign b_data_rd = r_b_data_rd;

endmodule
